// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer/response types, size codes and slave FSM states
package ahb_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_ERROR = 2'b01} hresp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  function automatic logic misaligned(input logic [7:0] lo, input logic [2:0] size);
    return |(lo & ((8'd1 << size) - 8'd1));
  endfunction
endpackage

// File: rtl/ahb_reg_bank.sv
// ahb_reg_bank: register storage with byte-lane writes and per-register write strobes
module ahb_reg_bank #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter int IW = 3,
  parameter int LB = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [IW-1:0]              idx,
  input  logic [LB-1:0]              lo,
  input  logic [2:0]                 size,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_d, wr_pulse_q;
  logic [DATA_W/8-1:0] be;
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_be
    assign be[b] = (LB'(b) >> size) == (lo >> size);
  end
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_pulse_d[i] = we && idx == IW'(i);
      regs_d[i] = regs_q[i];
      for (int j = 0; j < DATA_W/8; j++)
        regs_d[i][j*8 +: 8] = wr_pulse_d[i] && be[j] ? wdata[j*8 +: 8] : regs_q[i][j*8 +: 8];
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= rst ? RESET_VAL : regs_d[i];
    wr_pulse_q <= rst ? '0 : wr_pulse_d;
  end
  assign rdata = regs_q[idx];
  assign wr_pulse = wr_pulse_q;
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_out
    assign reg_out[r*DATA_W +: DATA_W] = regs_q[r];
  end
endmodule

// File: rtl/ahb_reg_slave.sv
// ahb_reg_slave: AHB-Lite register slave with programmable wait states and two-cycle ERROR responses
module ahb_reg_slave import ahb_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       HSEL,
  input  logic [ADDR_W-1:0]          HADDR,
  input  logic                       HWRITE,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HSIZE,
  input  logic [2:0]                 HBURST,
  input  logic [DATA_W-1:0]          HWDATA,
  input  logic                       HREADYIN,
  output logic                       HREADY,
  output logic [1:0]                 HRESP,
  output logic [DATA_W-1:0]          HRDATA,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);
  localparam int LB = $clog2(DATA_W/8);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  state_t state_d, state_q;
  hresp_t hresp_d, hresp_q;
  logic [3:0] cnt_d, cnt_q;
  logic dp_d, dp_q, wr_d, wr_q, hready_d, hready_q;
  logic [IW-1:0] idx_d, idx_q;
  logic [LB-1:0] lo_d, lo_q;
  logic [2:0] size_d, size_q;
  logic [ADDR_W-LB-1:0] full_idx;
  logic acc, bad, done, unused_burst;
  logic [DATA_W-1:0] rdata;
  assign unused_burst = ^HBURST;
  assign full_idx = HADDR[ADDR_W-1:LB];
  assign acc = HSEL && HREADYIN && hready_q && (HTRANS == HT_NONSEQ || HTRANS == HT_SEQ);
  assign bad = full_idx >= (ADDR_W-LB)'(NUM_REGS) || HSIZE > 3'(LB) || misaligned(8'(HADDR[LB-1:0]), HSIZE);
  assign done = state_q == ST_IDLE && dp_q;
  always_comb begin
    state_d = state_q;
    hresp_d = hresp_q;
    cnt_d = cnt_q;
    dp_d = dp_q;
    wr_d = wr_q;
    hready_d = hready_q;
    idx_d = idx_q;
    lo_d = lo_q;
    size_d = size_q;
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? ST_IDLE : ST_WAIT;
      hready_d = cnt_q == 4'd1;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
      hready_d = 1'b1;
    end else begin
      state_d = ST_IDLE;
      hresp_d = RESP_OKAY;
      hready_d = 1'b1;
      dp_d = 1'b0;
      if (acc) begin
        wr_d = HWRITE;
        idx_d = HADDR[LB +: IW];
        lo_d = HADDR[LB-1:0];
        size_d = HSIZE;
        dp_d = !bad;
        if (bad) begin
          state_d = ST_ERR1;
          hresp_d = RESP_ERROR;
          hready_d = 1'b0;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d = 4'(WAIT_STATES);
          hready_d = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge HCLK) begin
    state_q <= HRESET ? ST_IDLE : state_d;
    hresp_q <= HRESET ? RESP_OKAY : hresp_d;
    cnt_q <= HRESET ? 4'd0 : cnt_d;
    dp_q <= HRESET ? 1'b0 : dp_d;
    wr_q <= HRESET ? 1'b0 : wr_d;
    hready_q <= HRESET ? 1'b1 : hready_d;
    idx_q <= HRESET ? '0 : idx_d;
    lo_q <= HRESET ? '0 : lo_d;
    size_q <= HRESET ? 3'd0 : size_d;
  end
  ahb_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IW(IW), .LB(LB), .RESET_VAL(RESET_VAL)) u_bank (
    .clk(HCLK), .rst(HRESET), .we(done && wr_q), .idx(idx_q), .lo(lo_q), .size(size_q),
    .wdata(HWDATA), .rdata(rdata), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );
  assign HREADY = hready_q;
  assign HRESP = hresp_q;
  assign HRDATA = done && !wr_q ? rdata : '0;
endmodule

// File: tb/tb_ahb_reg_slave.sv
// tb_ahb_reg_slave: table, hand-written and randomized checks of ahb_reg_slave against a byte-level model
module tb_ahb_reg_slave;
  logic HCLK = 1'b0, HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS, HRESP;
  logic [2:0] HSIZE, HBURST;
  logic [255:0] reg_out;
  logic [7:0] wr_pulse;
  int total = 0, bad = 0;
  logic [31:0] mdl [8];
  typedef struct {
    logic sel; logic [1:0] tr; logic wr; logic [31:0] a; logic [2:0] sz; logic [31:0] wd;
    int ew; logic [1:0] er; logic [31:0] erd; logic [7:0] ep;
  } vec_t;
  vec_t tv[$];
  ahb_reg_slave #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .WAIT_STATES(2), .RESET_VAL('0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYIN(HREADY), .HREADY(HREADY),
    .HRESP(HRESP), .HRDATA(HRDATA), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [255:0] mflat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = mdl[i];
    return f;
  endfunction
  task automatic predict(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, output int ew, output logic [1:0] er0,
                         output logic [1:0] erf, output logic [31:0] erd, output logic [7:0] ep);
    int idx, bytes;
    logic acc, legal;
    acc = sel && (tr == 2'b10 || tr == 2'b11);
    idx = int'(a / 4);
    bytes = 1 << sz;
    legal = idx < 8 && sz <= 2 && (a % bytes) == 0;
    ew = !acc ? 0 : legal ? 2 : 1;
    er0 = {1'b0, acc && !legal};
    erf = er0;
    erd = acc && legal && !wr ? mdl[idx] : 32'h0;
    ep = acc && legal && wr ? 8'(1 << idx) : 8'h0;
    if (acc && legal && wr)
      for (int k = 0; k < bytes; k++) mdl[idx][8*((a % 4) + k) +: 8] = wd[8*((a % 4) + k) +: 8];
  endtask
  task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd, output int w, output logic [1:0] r0,
                      output logic [1:0] rf, output logic [31:0] rd, output logic [7:0] p1, output logic [7:0] p2);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz; HBURST = 3'($urandom_range(0, 7));
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    w = 0;
    @(negedge HCLK);
    r0 = HRESP;
    while (!HREADY && w < 20) begin
      w++;
      @(negedge HCLK);
    end
    rf = HRESP;
    rd = HRDATA;
    @(negedge HCLK);
    p1 = wr_pulse;
    @(negedge HCLK);
    p2 = wr_pulse;
    @(posedge HCLK); #1;
  endtask
  task automatic run_rand(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd);
    int ew, w;
    logic [1:0] er0, erf, r0, rf;
    logic [31:0] erd, rd;
    logic [7:0] ep, p1, p2;
    predict(sel, tr, wr, a, sz, wd, ew, er0, erf, erd, ep);
    xfer(sel, tr, wr, a, sz, wd, w, r0, rf, rd, p1, p2);
    chk($sformatf("rnd_waits a=%0h sz=%0d tr=%0d", a, sz, tr), 256'(w), 256'(ew));
    chk("rnd_first_resp", 256'(r0), 256'(er0));
    chk("rnd_final_resp", 256'(rf), 256'(erf));
    chk("rnd_rdata", 256'(rd), 256'(erd));
    chk("rnd_pulse", 256'(p1), 256'(ep));
    chk("rnd_pulse_len", 256'(p2), 256'(0));
    chk("rnd_regs", reg_out, mflat());
  endtask
  initial begin
    int w, dummy;
    logic [1:0] r0, rf, d0, d1;
    logic [31:0] rd, d2, a;
    logic [7:0] p1, p2, d3, pw;
    logic [2:0] sz;
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h0C, 3'd2, 32'h0, 2, 2'b00, 32'h00000000, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b1, 32'h0C, 3'd2, 32'hDEADBEEF, 2, 2'b00, 32'h0, 8'h08});
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h0C, 3'd2, 32'h0, 2, 2'b00, 32'hDEADBEEF, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b1, 32'h0D, 3'd0, 32'h0000AA00, 2, 2'b00, 32'h0, 8'h08});
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h0C, 3'd2, 32'h0, 2, 2'b00, 32'hDEADAAEF, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0, 1, 2'b01, 32'h0, 8'h00});
    tv.push_back('{1'b1, 2'b00, 1'b1, 32'h0C, 3'd2, 32'h11111111, 0, 2'b00, 32'h0, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b1, 32'h0E, 3'd1, 32'h12340000, 2, 2'b00, 32'h0, 8'h08});
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h0C, 3'd2, 32'h0, 2, 2'b00, 32'h1234AAEF, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b1, 32'h12, 3'd2, 32'h22222222, 1, 2'b01, 32'h0, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 3'd3, 32'h0, 1, 2'b01, 32'h0, 8'h00});
    tv.push_back('{1'b0, 2'b10, 1'b1, 32'h00, 3'd2, 32'h33333333, 0, 2'b00, 32'h0, 8'h00});
    tv.push_back('{1'b1, 2'b01, 1'b1, 32'h00, 3'd2, 32'h44444444, 0, 2'b00, 32'h0, 8'h00});
    tv.push_back('{1'b1, 2'b11, 1'b1, 32'h1C, 3'd2, 32'hCAFEF00D, 2, 2'b00, 32'h0, 8'h80});
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h1C, 3'd2, 32'h0, 2, 2'b00, 32'hCAFEF00D, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b1, 32'h0F, 3'd1, 32'h55555555, 1, 2'b01, 32'h0, 8'h00});
    tv.push_back('{1'b1, 2'b10, 1'b0, 32'h0C, 3'd2, 32'h0, 2, 2'b00, 32'h1234AAEF, 8'h00});
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd0; HBURST = 3'd0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_hready", 256'(HREADY), 256'(1));
    chk("rst_hresp", 256'(HRESP), 256'(0));
    chk("rst_hrdata", 256'(HRDATA), 256'(0));
    chk("rst_pulse", 256'(wr_pulse), 256'(0));
    chk("rst_regs", reg_out, 256'(0));
    @(posedge HCLK); #1;
    foreach (tv[i]) begin
      predict(tv[i].sel, tv[i].tr, tv[i].wr, tv[i].a, tv[i].sz, tv[i].wd, dummy, d0, d1, d2, d3);
      xfer(tv[i].sel, tv[i].tr, tv[i].wr, tv[i].a, tv[i].sz, tv[i].wd, w, r0, rf, rd, p1, p2);
      chk($sformatf("vec%0d_waits", i), 256'(w), 256'(tv[i].ew));
      chk($sformatf("vec%0d_first_resp", i), 256'(r0), 256'(tv[i].er));
      chk($sformatf("vec%0d_resp", i), 256'(rf), 256'(tv[i].er));
      chk($sformatf("vec%0d_rdata", i), 256'(rd), 256'(tv[i].erd));
      chk($sformatf("vec%0d_pulse", i), 256'(p1), 256'(tv[i].ep));
      chk($sformatf("vec%0d_pulse_len", i), 256'(p2), 256'(0));
      chk($sformatf("vec%0d_regs", i), reg_out, mflat());
    end
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h18; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HWRITE = 1'b0; HWDATA = 32'hA5A55A5A;
    w = 0;
    @(negedge HCLK);
    while (!HREADY && w < 20) begin
      w++;
      @(negedge HCLK);
    end
    chk("b2b_write_waits", 256'(w), 256'(2));
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    w = 0;
    @(negedge HCLK);
    while (!HREADY && w < 20) begin
      w++;
      @(negedge HCLK);
    end
    chk("b2b_read_waits", 256'(w), 256'(2));
    chk("b2b_read_data", 256'(HRDATA), 256'(32'hA5A55A5A));
    mdl[6] = 32'hA5A55A5A;
    repeat (2) @(negedge HCLK);
    chk("b2b_regs", reg_out, mflat());
    @(posedge HCLK); #1;
    for (int n = 0; n < 150; n++) begin
      sz = 3'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 39));
      if (($urandom % 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      run_rand(($urandom % 8) != 0, 2'($urandom), 1'($urandom), a, sz, $urandom);
    end
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0C; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55AA55AA; HRESET = 1'b1;
    @(negedge HCLK);
    pw = wr_pulse;
    chk("mid_rst_in_wait", 256'(HREADY), 256'(0));
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    pw = pw | wr_pulse;
    chk("mid_rst_hready", 256'(HREADY), 256'(1));
    chk("mid_rst_hresp", 256'(HRESP), 256'(0));
    chk("mid_rst_regs", reg_out, 256'(0));
    repeat (3) begin
      @(negedge HCLK);
      pw = pw | wr_pulse;
    end
    chk("mid_rst_no_pulse", 256'(pw), 256'(0));
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    @(posedge HCLK); #1;
    run_rand(1'b1, 2'b10, 1'b0, 32'h0C, 3'd2, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ahb_reg_slave.md
AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

Interface
REQ-001 Parameter DATA_W, 32, data bus width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, 32, HADDR width.
REQ-003 Parameter NUM_REGS, 8, register count; any value from 1 to 256.
REQ-004 Parameter WAIT_STATES, 0, wait cycles inserted per OKAY transfer; range 0..15.
REQ-005 Parameter RESET_VAL, 0, reset value of every register.
REQ-006 Port HCLK, input, 1, the only clock; all logic on its rising edge.
REQ-007 Port HRESET, input, 1, reset; synchronous, active-high.
REQ-008 Port HSEL, input, 1, slave select.
REQ-009 Port HADDR, input, ADDR_W, byte address.
REQ-010 Port HWRITE, input, 1, 1 = write.
REQ-011 Port HTRANS, input, 2, transfer type.
REQ-012 Port HSIZE, input, 3, transfer size.
REQ-013 Port HBURST, input, 3, burst type; ignored, every beat is handled as a single transfer.
REQ-014 Port HWDATA, input, DATA_W, write data.
REQ-015 Port HREADYIN, input, 1, bus-wide HREADY; tied to HREADY in single-slave systems.
REQ-016 Port HREADY, output, 1, slave ready.
REQ-017 Port HRESP, output, 2, response: 00 = OKAY, 01 = ERROR.
REQ-018 Port HRDATA, output, DATA_W, read data.
REQ-019 Port reg_out, output, NUM_REGS*DATA_W, flat register contents for the core.
REQ-020 Port wr_pulse, output, NUM_REGS, one-cycle strobe per register written.

Function
REQ-021 Address phase SHALL be accepted only when HSEL=1, HREADYIN=1 and HTRANS is NONSEQ (10) or SEQ (11); HADDR, HWRITE and HSIZE SHALL be latched at acceptance.
REQ-022 IDLE (00) or BUSY (01) transfers, or HSEL=0, SHALL get a zero-wait OKAY with no register change.
REQ-023 Register index SHALL be HADDR[ADDR_W-1 : log2(DATA_W/8)]; an index >= NUM_REGS SHALL produce ERROR.
REQ-024 HSIZE > log2(DATA_W/8), or an HADDR not aligned to HSIZE, SHALL produce ERROR.
REQ-025 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-026 FSM transitions on acceptance from IDLE: legal transfer with WAIT_STATES > 0 goes to WAIT; legal transfer with WAIT_STATES = 0 completes in IDLE; illegal transfer goes to ERR1.
REQ-027 WAIT SHALL drive HREADY=0 and HRESP=00 for exactly WAIT_STATES cycles, counted by a down-counter, then complete with HREADY=1 and return to IDLE.
REQ-028 ERR1 SHALL drive HREADY=0, HRESP=01; ERR2 SHALL drive HREADY=1, HRESP=01, then return to IDLE or accept a new address phase.
REQ-029 Write data SHALL be taken from HWDATA in the final data-phase cycle (HREADY=1); only byte lanes selected by HSIZE and the latched HADDR low bits SHALL update.
REQ-030 wr_pulse[index] SHALL pulse 1 in the cycle after the write completes.
REQ-031 HRDATA SHALL equal the full register at the latched index during the final read data-phase cycle; otherwise HRDATA SHALL be 0.
REQ-032 Back-to-back write A then read A SHALL return the newly written data.
REQ-033 ERROR transfers SHALL never modify registers or assert wr_pulse.
REQ-034 No address phase SHALL be accepted while HREADY=0.

Reset
REQ-035 While HRESET=1 at a clock edge, the block SHALL go to FSM IDLE, clear the counter, set every register to RESET_VAL, and drive HREADY=1, HRESP=00, HRDATA=0, wr_pulse=0.
REQ-036 Reset mid-transfer SHALL abandon the transfer with no register update.

Structure
REQ-037 Shared package ahb_pkg SHALL hold the htrans_t and hresp_t enums, the HSIZE constants and the FSM state enum.
REQ-038 Storage and byte-lane write logic SHALL live in sub-module ahb_reg_bank.

Verification (DATA_W=32, NUM_REGS=8, WAIT_STATES=2, RESET_VAL=0)
REQ-039 Reset, then read 0x0C -> HREADY=1, HRESP=00, HRDATA=0x00000000.
REQ-040 Word write 0xDEADBEEF to 0x0C -> HREADY low 2 cycles then high, wr_pulse[3] for 1 cycle; readback 0xDEADBEEF.
REQ-041 Byte write to 0x0D with HWDATA=0x0000AA00 -> register 3 = 0xDEADAAEF.
REQ-042 Read 0x20 -> HREADY=0/HRESP=01, then HREADY=1/HRESP=01; all registers unchanged.
REQ-043 HSEL=1, HTRANS=00 -> zero-wait OKAY, wr_pulse=0.
REQ-044 HRESET during WAIT of a write -> next cycle HREADY=1, all registers 0, wr_pulse never asserted.
